// File: rtl/simd_pkg.sv
// ---------------------------------------------------------------------------
// simd_pkg - shared load-select/loader-state types and default datapath sizes
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package simd_pkg;

   localparam int DEF_PE_COUNT   = 4;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_INS_WIDTH  = 64;

   typedef enum logic [1:0] {
      SEL_A    = 2'd0,
      SEL_B    = 2'd1,
      SEL_INS  = 2'd2,
      SEL_RSVD = 2'd3
   } load_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/line_packer.sv
// ---------------------------------------------------------------------------
// line_packer - gathers stream words into a zero-filled line, lane 0 in LSBs
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module line_packer #(
   parameter int MAX_WPL    = 4,
   parameter int DATA_WIDTH = 32,
   localparam int CW        = $clog2(MAX_WPL + 1)
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          clear,
   input  logic [CW-1:0]                 wpl,
   input  logic                          accept,
   input  logic [DATA_WIDTH-1:0]         data,
   input  logic                          last,
   output logic [MAX_WPL*DATA_WIDTH-1:0] line_data,
   output logic                          line_done
);

   logic [MAX_WPL-1:0][DATA_WIDTH-1:0] lanes_q;
   logic [MAX_WPL-1:0][DATA_WIDTH-1:0] merged;
   logic [CW-1:0]                      count_q;

   // The word being accepted is merged in combinationally so the line can be
   // registered into the BRAM port on the same edge that accepts it.
   always_comb begin
      line_done = accept && (last || (count_q == wpl - CW'(1)));
      merged    = lanes_q;
      for (int i = 0; i < MAX_WPL; i++) begin
         if (accept && (count_q == CW'(i))) begin
            merged[i] = data;
         end
      end
   end

   assign line_data = merged;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         lanes_q <= '0;
         count_q <= '0;
      end else if (clear || line_done) begin
         lanes_q <= '0;
         count_q <= '0;
      end else if (accept) begin
         lanes_q <= merged;
         count_q <= count_q + CW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/bram_loader.sv
// ---------------------------------------------------------------------------
// bram_loader - streams words into A/B/INS BRAM lines; LOADER_CHECKSUM_EN adds
// a per-transfer wrapping checksum output.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bram_loader
   import simd_pkg::*;
#(
   parameter int PE_COUNT       = DEF_PE_COUNT,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int BRAM_DEPTH     = 1024,
   parameter int ADDR_WIDTH     = $clog2(BRAM_DEPTH),
   parameter int INS_ADDR_WIDTH = 10,
   parameter int INS_WIDTH      = DEF_INS_WIDTH,
   localparam int AMAX          = (INS_ADDR_WIDTH > ADDR_WIDTH) ? INS_ADDR_WIDTH : ADDR_WIDTH,
   localparam int LW            = ADDR_WIDTH + 1
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic [1:0]                       cmd_sel,
   input  logic [AMAX-1:0]                  cmd_base,
   input  logic [LW-1:0]                    cmd_len,
   input  logic                             s_valid,
   output logic                             s_ready,
   input  logic [DATA_WIDTH-1:0]            s_data,
   input  logic                             s_last,
   output logic                             bram_a_wr_en,
   output logic [ADDR_WIDTH-1:0]            bram_a_wr_addr,
   output logic [PE_COUNT*DATA_WIDTH-1:0]   bram_a_wr_data,
   output logic                             bram_b_wr_en,
   output logic [ADDR_WIDTH-1:0]            bram_b_wr_addr,
   output logic [PE_COUNT*DATA_WIDTH-1:0]   bram_b_wr_data,
   output logic                             bram_ins_wr_en,
   output logic [INS_ADDR_WIDTH-1:0]        bram_ins_wr_addr,
   output logic [INS_WIDTH-1:0]             bram_ins_wr_data,
`ifdef LOADER_CHECKSUM_EN
   output logic [DATA_WIDTH-1:0]            checksum,
`endif
   output logic                             busy,
   output logic                             done,
   output logic [LW-1:0]                    lines_written
);

   localparam int WPL_INS = INS_WIDTH / DATA_WIDTH;
   localparam int MAX_WPL = (PE_COUNT > WPL_INS) ? PE_COUNT : WPL_INS;
   localparam int CW      = $clog2(MAX_WPL + 1);

   loader_state_e                   state_q, state_d;
   load_sel_e                       sel_q;
   logic [AMAX-1:0]                 base_q;
   logic [LW-1:0]                   len_q;
   logic [LW-1:0]                   line_q;
   logic                            handshake;
   logic                            accept;
   logic                            line_done;
   logic [CW-1:0]                   wpl;
   logic [MAX_WPL*DATA_WIDTH-1:0]   line_data;
   logic [ADDR_WIDTH-1:0]           ab_addr;
   logic [INS_ADDR_WIDTH-1:0]       ins_addr;

   assign wpl      = (sel_q == SEL_INS) ? CW'(WPL_INS) : CW'(PE_COUNT);
   assign ab_addr  = base_q[ADDR_WIDTH-1:0] + line_q[ADDR_WIDTH-1:0];
   assign ins_addr = base_q[INS_ADDR_WIDTH-1:0] + INS_ADDR_WIDTH'(line_q);

   line_packer #(
      .MAX_WPL    (MAX_WPL),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_packer (
      .clk       (clk),
      .rstn      (rstn),
      .clear     (handshake),
      .wpl       (wpl),
      .accept    (accept),
      .data      (s_data),
      .last      (s_last),
      .line_data (line_data),
      .line_done (line_done)
   );

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      s_ready   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      handshake = 1'b0;
      accept    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               handshake = 1'b1;
               state_d   = ((cmd_len == '0) || (load_sel_e'(cmd_sel) == SEL_RSVD)) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            accept  = s_valid;
            if (line_done && (s_last || (line_q + LW'(1) == len_q))) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            busy    = 1'b1;
            state_d = ST_DONE;
         end
         default: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q          <= ST_IDLE;
         sel_q            <= SEL_A;
         base_q           <= '0;
         len_q            <= '0;
         line_q           <= '0;
         lines_written    <= '0;
         bram_a_wr_en     <= 1'b0;
         bram_a_wr_addr   <= '0;
         bram_a_wr_data   <= '0;
         bram_b_wr_en     <= 1'b0;
         bram_b_wr_addr   <= '0;
         bram_b_wr_data   <= '0;
         bram_ins_wr_en   <= 1'b0;
         bram_ins_wr_addr <= '0;
         bram_ins_wr_data <= '0;
      end else begin
         state_q        <= state_d;
         bram_a_wr_en   <= 1'b0;
         bram_b_wr_en   <= 1'b0;
         bram_ins_wr_en <= 1'b0;
         if (handshake) begin
            sel_q  <= load_sel_e'(cmd_sel);
            base_q <= cmd_base;
            len_q  <= cmd_len;
            line_q <= '0;
         end
         if (line_done) begin
            line_q <= line_q + LW'(1);
            case (sel_q)
               SEL_A: begin
                  bram_a_wr_en   <= 1'b1;
                  bram_a_wr_addr <= ab_addr;
                  bram_a_wr_data <= line_data[PE_COUNT*DATA_WIDTH-1:0];
               end
               SEL_B: begin
                  bram_b_wr_en   <= 1'b1;
                  bram_b_wr_addr <= ab_addr;
                  bram_b_wr_data <= line_data[PE_COUNT*DATA_WIDTH-1:0];
               end
               SEL_INS: begin
                  bram_ins_wr_en   <= 1'b1;
                  bram_ins_wr_addr <= ins_addr;
                  bram_ins_wr_data <= line_data[INS_WIDTH-1:0];
               end
               default: ;
            endcase
         end
         // Commands that skip LOAD report zero lines without touching line_q.
         if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            lines_written <= (state_q == ST_IDLE) ? '0 : line_q;
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!rstn) begin
         checksum <= '0;
      end else if (handshake) begin
         checksum <= '0;
      end else if (accept) begin
         checksum <= checksum + s_data;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bram_loader.sv
// ---------------------------------------------------------------------------
// tb_bram_loader - directed self-checking bench for bram_loader
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bram_loader;

   logic          clk;
   logic          rstn;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_sel;
   logic [9:0]    cmd_base;
   logic [10:0]   cmd_len;
   logic          s_valid;
   logic          s_ready;
   logic [31:0]   s_data;
   logic          s_last;
   logic          a_en, b_en, ins_en;
   logic [9:0]    a_addr, b_addr, ins_addr;
   logic [127:0]  a_data, b_data;
   logic [63:0]   ins_data;
   logic          busy;
   logic          done;
   logic [10:0]   lines_written;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]   checksum;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int a_cnt    = 0;
   int b_cnt    = 0;
   int ins_cnt  = 0;

   bram_loader dut (
      .clk              (clk),
      .rstn             (rstn),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_sel          (cmd_sel),
      .cmd_base         (cmd_base),
      .cmd_len          (cmd_len),
      .s_valid          (s_valid),
      .s_ready          (s_ready),
      .s_data           (s_data),
      .s_last           (s_last),
      .bram_a_wr_en     (a_en),
      .bram_a_wr_addr   (a_addr),
      .bram_a_wr_data   (a_data),
      .bram_b_wr_en     (b_en),
      .bram_b_wr_addr   (b_addr),
      .bram_b_wr_data   (b_data),
      .bram_ins_wr_en   (ins_en),
      .bram_ins_wr_addr (ins_addr),
      .bram_ins_wr_data (ins_data),
`ifdef LOADER_CHECKSUM_EN
      .checksum         (checksum),
`endif
      .busy             (busy),
      .done             (done),
      .lines_written    (lines_written)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (a_en)   a_cnt++;
      if (b_en)   b_cnt++;
      if (ins_en) ins_cnt++;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_cmd(input logic [1:0] sel, input logic [9:0] base, input logic [10:0] len);
      cmd_valid = 1'b1;
      cmd_sel   = sel;
      cmd_base  = base;
      cmd_len   = len;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input logic l);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0; cmd_valid = 1'b0; cmd_sel = 2'd0; cmd_base = '0; cmd_len = '0;
      s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      step(); step();
      rstn = 1'b1;
      step();

      // reset state
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_en", {a_en, b_en, ins_en}, 0);
      chk("rst_lines", lines_written, 0);
      chk("rst_a_addr", a_addr, 0);

      // A load, base 5, two lines
      issue_cmd(2'd0, 10'd5, 11'd2);
      chk("t1_busy", busy, 1);
      chk("t1_s_ready", s_ready, 1);
      send(32'd1, 1'b0);
      send(32'd2, 1'b0);
      send(32'd3, 1'b0);
      chk("t1_no_early_wr", a_en, 0);
      send(32'd4, 1'b0);
      chk("t1_a_en0", a_en, 1);
      chk("t1_a_addr0", a_addr, 10'd5);
      chk("t1_a_data0", a_data, 128'h00000004_00000003_00000002_00000001);
      send(32'd5, 1'b0);
      chk("t1_a_en_pulse", a_en, 0);
      send(32'd6, 1'b0);
      send(32'd7, 1'b0);
      send(32'd8, 1'b0);
      chk("t1_a_en1", a_en, 1);
      chk("t1_a_addr1", a_addr, 10'd6);
      chk("t1_a_data1", a_data, 128'h00000008_00000007_00000006_00000005);
      chk("t1_flush_s_ready", s_ready, 0);
      step();
      chk("t1_done", done, 1);
      chk("t1_lines", lines_written, 2);
      chk("t1_busy_done", busy, 0);
`ifdef LOADER_CHECKSUM_EN
      chk("t1_checksum", checksum, 36);
`endif
      step();
      chk("t1_done_pulse", done, 0);
      chk("t1_idle_ready", cmd_ready, 1);
      chk("t1_a_cnt", a_cnt, 2);
      chk("t1_b_ins_cnt", b_cnt + ins_cnt, 0);

      // INS load with address wrap
      issue_cmd(2'd2, 10'd1023, 11'd2);
      send(32'hA, 1'b0);
      chk("t2_no_early_wr", ins_en, 0);
      send(32'hB, 1'b0);
      chk("t2_ins_en0", ins_en, 1);
      chk("t2_ins_addr0", ins_addr, 10'd1023);
      chk("t2_ins_data0", ins_data, 64'h0000000B_0000000A);
      send(32'hC, 1'b0);
      send(32'hD, 1'b0);
      chk("t2_ins_en1", ins_en, 1);
      chk("t2_ins_addr1", ins_addr, 10'd0);
      chk("t2_ins_data1", ins_data, 64'h0000000D_0000000C);
      step();
      chk("t2_done", done, 1);
      chk("t2_lines", lines_written, 2);
      step();
      chk("t2_cnts", {a_cnt[7:0], b_cnt[7:0], ins_cnt[7:0]}, {8'd2, 8'd0, 8'd2});

      // early s_last on B
      issue_cmd(2'd1, 10'd0, 11'd4);
      send(32'd7, 1'b0);
      send(32'd8, 1'b0);
      send(32'd9, 1'b1);
      chk("t3_b_en", b_en, 1);
      chk("t3_b_addr", b_addr, 10'd0);
      chk("t3_b_data", b_data, 128'h00000000_00000009_00000008_00000007);
      chk("t3_s_ready_after", s_ready, 0);
      s_valid = 1'b1; s_data = 32'd99;
      step();
      chk("t3_done", done, 1);
      chk("t3_lines", lines_written, 1);
      chk("t3_excess_refused", s_ready, 0);
      step();
      s_valid = 1'b0;
      chk("t3_b_cnt", b_cnt, 1);

      // len=0 and reserved select
      issue_cmd(2'd0, 10'd3, 11'd0);
      chk("t4_len0_done", done, 1);
      chk("t4_len0_lines", lines_written, 0);
      step();
      issue_cmd(2'd3, 10'd3, 11'd3);
      chk("t4_rsvd_done", done, 1);
      chk("t4_rsvd_lines", lines_written, 0);
      step();
      chk("t4_no_writes", a_cnt + b_cnt + ins_cnt, 5);

      // reset mid-transfer
      issue_cmd(2'd0, 10'd10, 11'd1);
      send(32'd21, 1'b0);
      send(32'd22, 1'b0);
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      chk("t5_cmd_ready", cmd_ready, 1);
      chk("t5_busy", busy, 0);
      step(); step();
      chk("t5_no_write", a_cnt, 2);
      issue_cmd(2'd0, 10'd20, 11'd1);
      send(32'd11, 1'b0);
      send(32'd12, 1'b0);
      send(32'd13, 1'b0);
      send(32'd14, 1'b0);
      chk("t5_a_en", a_en, 1);
      chk("t5_a_addr", a_addr, 10'd20);
      chk("t5_a_data", a_data, 128'h0000000E_0000000D_0000000C_0000000B);
      step();
      chk("t5_done", done, 1);
      chk("t5_lines", lines_written, 1);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
